// File: rtl/ife_pkg.sv
// Shared types and defaults for the IFE block-queue consumers.
// Used by ife_slot_mux and ife_block_unpacker.
package ife_pkg;

    localparam int BLOCK_WIDTH_DEF = 128;
    localparam int INSTR_WIDTH_DEF = 32;

    typedef logic [INSTR_WIDTH_DEF-1:0] instr_t;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_DRAIN = 1'b1
    } unpack_state_e;

    function automatic int slots_f(input int block_width = BLOCK_WIDTH_DEF,
                                   input int instr_width = INSTR_WIDTH_DEF);
        return block_width / instr_width;
    endfunction

endpackage

// File: rtl/ife_slot_mux.sv
// Combinational selector: picks instruction slot 'slot' out of a block.
// Slot 0 is the least significant INSTR_WIDTH bits.
module ife_slot_mux
    import ife_pkg::*;
#(
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int SLOT_W      = $clog2(slots_f(BLOCK_WIDTH, INSTR_WIDTH))
) (
    input  logic [BLOCK_WIDTH-1:0] blk,
    input  logic [SLOT_W-1:0]      slot,
    output logic [INSTR_WIDTH-1:0] instr
);

    localparam int SLOTS = slots_f(BLOCK_WIDTH, INSTR_WIDTH);

    // NOTE: default assignment first so no path through the loop leaves instr unassigned (no latch).
    always_comb begin
        instr = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (slot == SLOT_W'(k)) begin
                instr = blk[k*INSTR_WIDTH +: INSTR_WIDTH];
            end
        end
    end

endmodule

// File: rtl/ife_block_unpacker.sv
// Pops instruction blocks from the show-ahead block queue and issues one slot per cycle.
// Optional macro IFE_SKIP_ZERO_EN: suppress all-zero slots instead of issuing them.
module ife_block_unpacker
    import ife_pkg::*;
#(
    parameter int                   BLOCK_WIDTH = 128,
    parameter int                   INSTR_WIDTH = 32,
    parameter int                   PC_WIDTH    = 64,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = 64'h0000_0000_8000_0000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   q_empty,
    input  logic [BLOCK_WIDTH-1:0]                 q_block,
    output logic                                   q_pop,
    input  logic                                   flush,
    input  logic [PC_WIDTH-1:0]                    flush_pc,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [INSTR_WIDTH-1:0]                 out_instr,
    output logic [PC_WIDTH-1:0]                    out_pc,
    output logic [$clog2(BLOCK_WIDTH/INSTR_WIDTH)-1:0] out_slot
);

    localparam int SLOTS  = slots_f(BLOCK_WIDTH, INSTR_WIDTH);
    localparam int SLOT_W = $clog2(SLOTS);

    localparam logic [0:0] ST_EMPTY = S_EMPTY;
    localparam logic [0:0] ST_DRAIN = S_DRAIN;

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INSTR_WIDTH / 8);
    localparam logic [SLOT_W-1:0]   LAST    = SLOT_W'(SLOTS - 1);

    logic [0:0]             state_q;
    logic [BLOCK_WIDTH-1:0] blk_q;
    logic [SLOT_W-1:0]      slot_q;
    logic [PC_WIDTH-1:0]    pc_q;

    logic [INSTR_WIDTH-1:0] cur_instr;
    logic                   draining;
    logic                   skip;
    logic                   advance;
    logic                   last;
    logic                   load;

    ife_slot_mux #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .SLOT_W      (SLOT_W)
    ) u_slot_mux (
        .blk   (blk_q),
        .slot  (slot_q),
        .instr (cur_instr)
    );

    assign draining = (state_q == ST_DRAIN);
    assign last     = (slot_q == LAST);

`ifdef IFE_SKIP_ZERO_EN
    assign skip = draining && (cur_instr == '0);
`else
    assign skip = 1'b0;
`endif

    // A skipped slot moves the cursor exactly as an accepted one would.
    assign out_valid = draining && !flush && !skip;
    assign advance   = draining && !flush && ((out_valid && out_ready) || skip);

    // The queue head is latched either when idle or when the last slot retires.
    assign load  = !rst && !flush && !q_empty && (!draining || (advance && last));
    assign q_pop = load;

    assign out_instr = draining ? cur_instr : '0;
    assign out_pc    = pc_q;
    assign out_slot  = slot_q;

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            blk_q   <= '0;
            slot_q  <= '0;
            pc_q    <= RESET_PC;
        end else if (flush) begin
            state_q <= ST_EMPTY;
            slot_q  <= '0;
            pc_q    <= flush_pc;
        end else begin
            if (advance) begin
                pc_q   <= pc_q + PC_STEP;
                slot_q <= last ? '0 : slot_q + SLOT_W'(1);
            end
            if (load) begin
                blk_q   <= q_block;
                slot_q  <= '0;
                state_q <= ST_DRAIN;
            end else if (advance && last) begin
                state_q <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_ife_block_unpacker.sv
// Directed self-checking bench for ife_block_unpacker with a small show-ahead queue model.
// Expectations for the zero-slot case follow IFE_SKIP_ZERO_EN when it is defined.
module tb_ife_block_unpacker;
    import ife_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         q_empty;
    logic [127:0] q_block;
    logic         q_pop;
    logic         flush;
    logic [63:0]  flush_pc;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_instr;
    logic [63:0]  out_pc;
    logic [1:0]   out_slot;

    logic [127:0] fifo [0:15];
    int           head = 0;
    int           tail = 0;
    int           pops = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    logic         pop_seen;

    ife_block_unpacker dut (
        .clk       (clk),
        .rst       (rst),
        .q_empty   (q_empty),
        .q_block   (q_block),
        .q_pop     (q_pop),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_slot  (out_slot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_q();
        q_empty = (head >= tail);
        q_block = q_empty ? '0 : fifo[head];
    endtask

    task automatic push(input logic [127:0] blk);
        fifo[tail] = blk;
        tail++;
        drive_q();
        #1;
    endtask

    // One clock: the queue model advances its head when q_pop was high before the edge.
    task automatic tick();
        pop_seen = q_pop;
        @(posedge clk);
        #1;
        if (pop_seen) begin
            head++;
            pops++;
        end
        drive_q();
        #1;
    endtask

    task automatic expect_slot(input string tag, input logic [127:0] blk, input int slot,
                               input logic [63:0] pc);
        instr_t exp_instr;
        exp_instr = blk[slot*32 +: 32];
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_instr"}, 64'(out_instr), 64'(exp_instr));
        check({tag, "_pc"},    out_pc,         pc);
        check({tag, "_slot"},  64'(out_slot),  64'(slot));
    endtask

    logic [127:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_f, blk_g, blk_h, blk_z, blk_y;
    logic [63:0]  pc;
    logic         exp_v;

    initial begin
        blk_a = 128'h44444444_33333333_22222222_11111111;
        blk_b = 128'h88888888_77777777_66666666_55555555;
        blk_c = 128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_99999999;
        blk_d = 128'hDDDD0004_DDDD0003_DDDD0002_DDDD0001;
        blk_e = 128'hEEEE0004_EEEE0003_EEEE0002_EEEE0001;
        blk_f = 128'hF0000004_F0000003_F0000002_F0000001;
        blk_g = 128'h60000004_60000003_60000002_60000001;
        blk_h = 128'h70000004_70000003_70000002_70000001;
        blk_z = 128'h00000000_000000AA_00000000_000000BB;
        blk_y = 128'h50000004_50000003_50000002_50000001;

        rst = 1'b1; flush = 1'b0; flush_pc = '0; out_ready = 1'b1;
        drive_q();
        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pc",    out_pc,         RST_PC);
        check("rst_slot",  64'(out_slot),  64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);

        // Single block; q_pop must stay low while reset is held.
        push(blk_a);
        check("rst_pop", 64'(q_pop), 64'd0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; #1;
        check("t1_pop", 64'(q_pop), 64'd1);
        check("t1_idle_valid", 64'(out_valid), 64'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_slot($sformatf("t1_s%0d", k), blk_a, k, RST_PC + 64'(4*k));
            check($sformatf("t1_nopop%0d", k), 64'(q_pop), 64'd0);
            tick();
        end
        check("t1_end_valid", 64'(out_valid), 64'd0);
        check("t1_end_instr", 64'(out_instr), 64'd0);
        check("t1_pops", 64'(pops), 64'd1);

        // Two blocks back to back, no bubble.
        pc = RST_PC + 64'h10;
        push(blk_b);
        push(blk_c);
        check("t2_pop1", 64'(q_pop), 64'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            expect_slot($sformatf("t2_i%0d", i), (i < 4) ? blk_b : blk_c, i % 4, pc);
            check($sformatf("t2_pop_i%0d", i), 64'(q_pop), (i == 3) ? 64'd1 : 64'd0);
            pc = pc + 64'd4;
            tick();
        end
        check("t2_end_valid", 64'(out_valid), 64'd0);
        check("t2_pops", 64'(pops), 64'd3);

        // Backpressure held on slot 1.
        push(blk_d);
        tick();
        expect_slot("t3_s0", blk_d, 0, pc);
        tick();
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            expect_slot($sformatf("t3_hold%0d", i), blk_d, 1, pc + 64'd4);
            tick();
        end
        out_ready = 1'b1;
        #1;
        expect_slot("t3_s1", blk_d, 1, pc + 64'd4);
        tick();
        expect_slot("t3_s2", blk_d, 2, pc + 64'd8);
        tick();
        expect_slot("t3_s3", blk_d, 3, pc + 64'd12);
        tick();
        check("t3_end_valid", 64'(out_valid), 64'd0);
        pc = pc + 64'h10;

        // Flush on slot 2.
        push(blk_e);
        tick();
        expect_slot("t4_s0", blk_e, 0, pc);
        tick();
        expect_slot("t4_s1", blk_e, 1, pc + 64'd4);
        tick();
        expect_slot("t4_s2", blk_e, 2, pc + 64'd8);
        flush = 1'b1; flush_pc = 64'h1000;
        #1;
        check("t4_flush_valid", 64'(out_valid), 64'd0);
        check("t4_flush_pop",   64'(q_pop),     64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("t4_after_valid", 64'(out_valid), 64'd0);
        push(blk_f);
        check("t4_pop_f", 64'(q_pop), 64'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_slot($sformatf("t4_f%0d", k), blk_f, k, 64'h1000 + 64'(4*k));
            tick();
        end
        check("t4_f_end_valid", 64'(out_valid), 64'd0);

        // Flush while idle with a block waiting: no pop that cycle.
        push(blk_g);
        flush = 1'b1; flush_pc = 64'h2000;
        #1;
        check("t5_flush_idle_pop", 64'(q_pop), 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("t5_pop_g", 64'(q_pop), 64'd1);
        tick();
        expect_slot("t5_g0", blk_g, 0, 64'h2000);
        tick();
        expect_slot("t5_g1", blk_g, 1, 64'h2004);

        // Asynchronous reset mid-block, away from the clock edge.
        push(blk_h);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_pc",    out_pc,         RST_PC);
        check("t6_rst_slot",  64'(out_slot),  64'd0);
        check("t6_rst_pop",   64'(q_pop),     64'd0);
        tick();
        check("t6_rst_pop2",  64'(q_pop),     64'd0);
        rst = 1'b0;
        #1;
        check("t6_pop_h", 64'(q_pop), 64'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            expect_slot($sformatf("t6_h%0d", k), blk_h, k, RST_PC + 64'(4*k));
            tick();
        end

        // Zero slots: suppressed with IFE_SKIP_ZERO_EN, issued otherwise.
        pc = RST_PC + 64'h10;
        push(blk_z);
        tick();
        for (int k = 0; k < 4; k++) begin
`ifdef IFE_SKIP_ZERO_EN
            exp_v = (k == 0 || k == 2);
`else
            exp_v = 1'b1;
`endif
            check($sformatf("t7_valid%0d", k), 64'(out_valid), 64'(exp_v));
            if (exp_v) begin
                expect_slot($sformatf("t7_z%0d", k), blk_z, k, pc + 64'(4*k));
            end
            if (k == 3) begin
                push(blk_y);
                check("t7_pop_y", 64'(q_pop), 64'd1);
            end
            tick();
        end
        expect_slot("t7_y0", blk_y, 0, pc + 64'h10);
        check("t7_pops", 64'(pops), 64'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
